spell_trace_judge: RTL
======================

# spell_trace_judge

Upstream judging stage for the score calculator. Once per video frame it compares the wand cursor position against the current waypoint of the active spell trace. It emits a one-cycle scoring strobe with a hit/miss level (`in_trace`) and advances through the waypoint path. It also runs the frame-based timers that drive the `powerUp1` (+150 bonus) and `powerUp4` (double points) levels consumed by the score calculator.

## Interface
- `COORD_W`, 10, cursor/waypoint coordinate width (unsigned pixels)
- `TOL`, 8, hit tolerance in pixels per axis (inclusive)
- `PATH_LEN`, 16, waypoints per trace (2..256)
- `POWER_FRAMES`, 300, power-up duration in frames
- `MISS_LIMIT`, 60, consecutive missed frames that abort a trace (used only with `TRACE_ABORT_EN`)

Ports:
- `clock` in 1: single system clock
- `resetn` in 1: asynchronous active-low reset
- `frame_tick` in 1: one-cycle pulse per video frame
- `trace_start` in 1: one-cycle pulse that begins or restarts a trace
- `cursor_x`, `cursor_y` in `COORD_W`: wand position, stable around `frame_tick`
- `wp_x`, `wp_y` in `COORD_W`: waypoint at `wp_addr`, combinational ROM read with zero latency
- `pickup_bonus`, `pickup_double` in 1: one-cycle power-up pickup pulses
- `wp_addr` out `clog2(PATH_LEN)`: current waypoint index
- `active` out 1: high in TRACK
- `score_strobe` out 1: one-cycle judgement event
- `in_trace` out 1: 1 for a hit, 0 for a miss; valid with `score_strobe` and held until the next strobe
- `trace_done` out 1: one-cycle pulse when the path completes
- `trace_abort` out 1: one-cycle pulse when a trace is aborted
- `powerUp1`, `powerUp4` out 1: power-up active levels

## Operation
- The FSM has three states: IDLE, TRACK and DONE. Reset puts it in IDLE.
- **IDLE:** `trace_start` moves to TRACK and clears `wp_addr` and the miss counter to 0.
- **TRACK:** on each `frame_tick`:
  - hit = |cursor_x−wp_x| ≤ TOL and |cursor_y−wp_y| ≤ TOL.
  - Compute both differences as unsigned `COORD_W+1`-bit values; no wrap.
  - **Hit:** assert the strobe with `in_trace`=1 and clear the miss counter. If `wp_addr`=PATH_LEN−1, go to DONE; otherwise increment `wp_addr`.
  - **Miss:** assert the strobe with `in_trace`=0, increment the miss counter (saturating), and leave `wp_addr` unchanged.
- **DONE:** pulse `trace_done` for one cycle, then go to IDLE. `wp_addr` holds at PATH_LEN−1 until the next start.
- `trace_start` in TRACK or DONE restarts the trace: `wp_addr`=0, no strobe is produced that cycle, and the state is TRACK. `trace_start` takes priority over a coincident `frame_tick`.
- **Power-up timers** (one per power-up, width `clog2(POWER_FRAMES+1)`):
  - A pickup loads its timer with POWER_FRAMES.
  - Each timer decrements on `frame_tick` while nonzero.
  - Each output is high exactly while its timer is nonzero.
  - The power-ups are mutually exclusive: a pickup clears the other timer.
  - If both pickups arrive in the same cycle, `pickup_double` wins.
  - A load beats a coincident decrement.
  - Timers run in every FSM state.
- **Reset:** state IDLE, `wp_addr`=0, and all outputs 0 (`active`, `score_strobe`, `in_trace`, `trace_done`, `trace_abort`, `powerUp1`, `powerUp4`). Timers and the miss counter are 0. Asserting reset mid-trace drops everything immediately.

## Timing
- All outputs are registered.
- `score_strobe`/`in_trace` appear the cycle after the judged `frame_tick` and are sampled from cursor and waypoint values in the `frame_tick` cycle.
- `wp_addr` updates in the same cycle as the strobe. The new waypoint is valid for the next frame.
- `trace_done` is asserted the cycle after the final hit strobe. `active` falls in that same cycle.
- `powerUp1`/`powerUp4` rise the cycle after the pickup and fall the cycle after the `frame_tick` that decrements the timer to 0. The active window is exactly POWER_FRAMES frame ticks.
- `frame_tick` is assumed to be at least 2 cycles apart. Back-to-back ticks are still each judged; there is no drop.

## Configuration
- `TRACE_ABORT_EN` defined:
  - In TRACK, reaching MISS_LIMIT consecutive misses aborts the trace.
  - The miss strobe is still issued, `trace_abort` pulses in the same cycle, and the FSM goes to IDLE.
- Undefined:
  - There is no abort; the miss counter and `trace_abort` logic are removed and `trace_abort` is tied 0.
  - A trace ends only through DONE or a restart.

## Test plan
- **Full path:** reset, `trace_start`, then cursor placed on each waypoint for 16 ticks. Expect 16 strobes with `in_trace`=1, `wp_addr` going 0→15, `trace_done` one cycle after the 16th strobe, and `active`=0.
- **Tolerance edge:** waypoint (100,100). Cursor (108,92) gives a hit. Cursor (109,100) gives a miss with `wp_addr` unchanged. Cursor (0,0) against waypoint (5,5) gives a hit with no underflow.
- **Power timers:** `pickup_bonus` makes `powerUp1`=1 for exactly 300 ticks. Then `pickup_double` at tick 100 of a new bonus gives `powerUp1`=0 and `powerUp4`=1. Simultaneous pickups give only `powerUp4`.
- **Restart:** restart at `wp_addr`=7 with a coincident `frame_tick` gives `wp_addr`=0, no strobe, and `active`=1.
- **Abort (`TRACE_ABORT_EN`):** 60 consecutive misses give `trace_abort` on the 60th strobe and the FSM in IDLE. 59 misses then a hit keep TRACK with the counter cleared. With the macro undefined, 100 misses give no abort.
- **Reset mid-trace:** assert `resetn`=0 asynchronously with `powerUp4`=1 at `wp_addr`=5. All outputs go to 0 immediately, and the block stays in IDLE after release.

Source files
------------

// File: rtl/spell_trace_judge.sv
// Per-frame wand/waypoint judge with scoring strobe, path sequencing and power-up frame timers.
// Optional build macro TRACE_ABORT_EN: abort a trace after MISS_LIMIT consecutive misses.
module spell_trace_judge #(
    parameter int COORD_W      = 10,
    parameter int TOL          = 8,
    parameter int PATH_LEN     = 16,
    parameter int POWER_FRAMES = 300,
    parameter int MISS_LIMIT   = 60
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        frame_tick,
    input  logic                        trace_start,
    input  logic [COORD_W-1:0]          cursor_x,
    input  logic [COORD_W-1:0]          cursor_y,
    input  logic [COORD_W-1:0]          wp_x,
    input  logic [COORD_W-1:0]          wp_y,
    input  logic                        pickup_bonus,
    input  logic                        pickup_double,
    output logic [$clog2(PATH_LEN)-1:0] wp_addr,
    output logic                        active,
    output logic                        score_strobe,
    output logic                        in_trace,
    output logic                        trace_done,
    output logic                        trace_abort,
    output logic                        powerUp1,
    output logic                        powerUp4,
    output logic [1:0]                  dbg_state
);

    localparam int ADDR_W = $clog2(PATH_LEN);
    localparam int TMR_W  = $clog2(POWER_FRAMES + 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(PATH_LEN - 1);
    localparam logic [COORD_W:0]   TOL_W     = (COORD_W + 1)'(TOL);
    localparam logic [TMR_W-1:0]   TMR_LOAD  = TMR_W'(POWER_FRAMES);

    // Handshake-free block: every input is a one-cycle pulse or a level sampled on frame_tick.
    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, DONE = 2'd2} state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   addr_next;
    logic                strobe_next, in_trace_next;
    logic                done_pend, done_pend_next;
    logic [COORD_W:0]    dx, dy;
    logic                hit;
    logic [TMR_W-1:0]    tmr_bonus, tmr_double;

`ifdef TRACE_ABORT_EN
    localparam int MISS_W = $clog2(MISS_LIMIT + 1);
    localparam logic [MISS_W-1:0] MISS_MAX   = MISS_W'(MISS_LIMIT);
    localparam logic [MISS_W-1:0] MISS_ABORT = MISS_W'(MISS_LIMIT - 1);
    logic [MISS_W-1:0]   miss_cnt, miss_next;
    logic                abort_next;
`endif

    // Differences are widened by one bit so neither direction can wrap.
    always_comb begin
        dx = (cursor_x >= wp_x) ? ({1'b0, cursor_x} - {1'b0, wp_x}) : ({1'b0, wp_x} - {1'b0, cursor_x});
        dy = (cursor_y >= wp_y) ? ({1'b0, cursor_y} - {1'b0, wp_y}) : ({1'b0, wp_y} - {1'b0, cursor_y});
        hit = (dx <= TOL_W) && (dy <= TOL_W);
    end

    always_comb begin
        state_next     = state;
        addr_next      = wp_addr;
        strobe_next    = 1'b0;
        in_trace_next  = in_trace;
        done_pend_next = done_pend;
`ifdef TRACE_ABORT_EN
        miss_next      = miss_cnt;
        abort_next     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (trace_start) begin
                    state_next = TRACK;
                    addr_next  = '0;
`ifdef TRACE_ABORT_EN
                    miss_next  = '0;
`endif
                end
            end
            TRACK: begin
                if (trace_start) begin
                    addr_next      = '0;
                    done_pend_next = 1'b0;
`ifdef TRACE_ABORT_EN
                    miss_next      = '0;
`endif
                // The final hit strobe is shown in TRACK; DONE follows one cycle later.
                end else if (done_pend) begin
                    state_next     = DONE;
                    done_pend_next = 1'b0;
                end else if (frame_tick) begin
                    strobe_next   = 1'b1;
                    in_trace_next = hit;
                    if (hit) begin
`ifdef TRACE_ABORT_EN
                        miss_next = '0;
`endif
                        if (wp_addr == LAST_ADDR) done_pend_next = 1'b1;
                        else                      addr_next      = wp_addr + 1'b1;
                    end else begin
`ifdef TRACE_ABORT_EN
                        if (miss_cnt != MISS_MAX) miss_next = miss_cnt + 1'b1;
                        if (miss_cnt >= MISS_ABORT) begin
                            abort_next = 1'b1;
                            state_next = IDLE;
                        end
`endif
                    end
                end
            end
            DONE: begin
                if (trace_start) begin
                    state_next = TRACK;
                    addr_next  = '0;
`ifdef TRACE_ABORT_EN
                    miss_next  = '0;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            wp_addr      <= '0;
            score_strobe <= 1'b0;
            in_trace     <= 1'b0;
            done_pend    <= 1'b0;
        end else begin
            state        <= state_next;
            wp_addr      <= addr_next;
            score_strobe <= strobe_next;
            in_trace     <= in_trace_next;
            done_pend    <= done_pend_next;
        end
    end

`ifdef TRACE_ABORT_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            miss_cnt    <= '0;
            trace_abort <= 1'b0;
        end else begin
            miss_cnt    <= miss_next;
            trace_abort <= abort_next;
        end
    end
`else
    assign trace_abort = 1'b0;
`endif

    // Pickups are exclusive; double wins a tie and any load overrides a coincident decrement.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tmr_bonus  <= '0;
            tmr_double <= '0;
        end else if (pickup_double) begin
            tmr_double <= TMR_LOAD;
            tmr_bonus  <= '0;
        end else if (pickup_bonus) begin
            tmr_bonus  <= TMR_LOAD;
            tmr_double <= '0;
        end else if (frame_tick) begin
            if (tmr_bonus != '0)  tmr_bonus  <= tmr_bonus - 1'b1;
            if (tmr_double != '0) tmr_double <= tmr_double - 1'b1;
        end
    end

    assign active     = (state == TRACK);
    assign trace_done = (state == DONE);
    assign powerUp1   = (tmr_bonus != '0);
    assign powerUp4   = (tmr_double != '0);
    assign dbg_state  = state;

endmodule
